adc_emulator: RTL and testbench
===============================

ADC_EMULATOR -- requirements
Module: adc_emulator

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 10, meaning CLK cycles in CONV state before readout is enabled (valid 1..1023).
REQ-002 SHALL have parameter RAMP_STEP, default 1, meaning 16-bit increment applied per conversion in ramp mode.
REQ-003 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port CNV  in  1  conversion start from controller; asynchronous to CLK.
REQ-006 SHALL have port SCK  in  1  serial clock from controller; asynchronous to CLK.
REQ-007 SHALL have port MODE  in  1  0 = static sample registers, 1 = ramp.
REQ-008 SHALL have ports DIN  in  16, DIN_CH  in  3, DIN_WE  in  1  host write of sample register DIN_CH (0 = channel 1).
REQ-009 SHALL have ports SDO1..SDO8  out  1 each  serial data per channel, MSB first.
REQ-010 SHALL have port CLKOUT  out  1  echo of synchronized SCK.
REQ-011 SHALL have ports BUSY  out  1  high in CONV; ERR  out  1  sticky protocol-error flag.

Function
REQ-012 SHALL pass CNV and SCK through 2-flop synchronizers plus a third history flop; rise/fall "detected" = sync and history differ.
REQ-013 SHALL implement states IDLE, CONV, READY, SHIFT.
REQ-014 SHALL, on detected CNV rise in IDLE or READY, copy all 8 sample registers into 8 16-bit shift registers and enter CONV in the next cycle.
REQ-015 SHALL, in ramp mode, add RAMP_STEP to every sample register (modulo 2^16) in the same cycle as the copy; the copied value is the pre-increment value.
REQ-016 SHALL hold BUSY=1 for exactly CONV_CYCLES cycles in CONV, then enter READY with BUSY=0.
REQ-017 SHALL drive SDOn = bit 15 of shift register n in CONV, READY and SHIFT; SDOn=0 in IDLE.
REQ-018 SHALL, on each detected SCK fall in READY/SHIFT, shift all registers left by one (zero fill) and increment a 5-bit bit counter; first fall moves READY to SHIFT.
REQ-019 SHALL return to IDLE in the cycle after the 16th detected SCK fall; bit counter cleared.
REQ-020 SHALL drive CLKOUT = synchronized SCK registered once (3 CLK cycles total delay from pin).
REQ-021 SHALL ignore detected CNV rise during CONV and set ERR.
REQ-022 SHALL, on detected CNV rise during SHIFT, abort readout, set ERR, and start a new conversion per REQ-014.
REQ-023 SHALL ignore SCK edges in IDLE and CONV; SCK fall in CONV sets ERR.
REQ-024 SHALL apply DIN_WE writes in any state; write and ramp increment to the same register in one cycle: write wins.
REQ-025 SHALL clear ERR only by RST.

Reset
REQ-026 SHALL, while RST=1, set state IDLE, SDO1..SDO8=0, CLKOUT=0, BUSY=0, ERR=0, bit counter 0, synchronizer flops 0, shift and sample registers 0.
REQ-027 SHALL honour RST mid-conversion or mid-shift, returning to IDLE the next cycle with no residual shift data.

Verification
REQ-028 Static: write ch1=0xA5C3, ch8=0x8001, CNV pulse, 16 SCK pulses -> controller recovers 0xA5C3 on SDO1, 0x8001 on SDO8, 0x0000 on others; ERR=0.
REQ-029 Timing: CNV rises at cycle 0 -> BUSY high cycles 4..13 (CONV_CYCLES=10), READY at 14; CLKOUT tracks SCK 3 cycles late.
REQ-030 Ramp: MODE=1, ch2=0xFFFF, RAMP_STEP=1, three conversions -> SDO2 words 0xFFFF, 0x0000, 0x0001.
REQ-031 Error: CNV rise during CONV -> ignored, BUSY duration unchanged, ERR=1; CNV rise after 5 SCK falls -> new CONV, ERR=1.
REQ-032 Reset: RST asserted after 8 SCK falls -> next cycle IDLE, SDO all 0, ERR=0; following full cycle reads correct words.
REQ-033 Write collision: MODE=1, DIN_WE to ch3=0x1234 same cycle as CNV copy -> this conversion outputs old value, next outputs 0x1234.

Source files
------------

// File: rtl/adc_emulator.sv
// adc_emulator: behavioural stand-in for an 8-channel simultaneous-sampling
// serial ADC. A controller pulses CNV to latch all channels, waits for BUSY to
// drop, then clocks 16 bits per channel out of SDO1..SDO8 with SCK (MSB first).
// Channel data comes from host-writable sample registers, optionally ramping.
`timescale 1ns/1ps
module adc_emulator #(
    parameter int unsigned CONV_CYCLES = 10,
    parameter logic [15:0] RAMP_STEP   = 16'd1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CNV,
    input  logic        SCK,
    input  logic        MODE,
    input  logic [15:0] DIN,
    input  logic [2:0]  DIN_CH,
    input  logic        DIN_WE,
    output logic        SDO1,
    output logic        SDO2,
    output logic        SDO3,
    output logic        SDO4,
    output logic        SDO5,
    output logic        SDO6,
    output logic        SDO7,
    output logic        SDO8,
    output logic        CLKOUT,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam logic [9:0] CONV_LAST = 10'(CONV_CYCLES - 1);

    logic        cnv_s1, cnv_s2, cnv_h;
    logic        sck_s1, sck_s2, sck_h;
    logic        cnv_rise, sck_fall;
    state_t      state, next_state;
    logic [9:0]  conv_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] sample [8];
    logic [15:0] shreg  [8];
    logic [7:0]  sdo;
    logic        do_copy, do_shift, set_err;

    // An edge is seen when the synchronized level differs from its history flop.
    assign cnv_rise = cnv_s2 & ~cnv_h;
    assign sck_fall = ~sck_s2 & sck_h;

    // Two-flop synchronizers plus a history flop for the controller's CNV and SCK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnv_s1 <= 1'b0;
            cnv_s2 <= 1'b0;
            cnv_h  <= 1'b0;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_h  <= 1'b0;
        end else begin
            cnv_s1 <= CNV;
            cnv_s2 <= cnv_s1;
            cnv_h  <= cnv_s2;
            sck_s1 <= SCK;
            sck_s2 <= sck_s1;
            sck_h  <= sck_s2;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the copy/shift/error strobes that drive the datapath.
    always_comb begin
        next_state = state;
        do_copy    = 1'b0;
        do_shift   = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (cnv_rise) begin
                    do_copy    = 1'b1;
                    next_state = CONV;
                end
            end
            CONV: begin
                set_err = cnv_rise | sck_fall;
                if (conv_cnt == CONV_LAST) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (cnv_rise) begin
                    do_copy    = 1'b1;
                    next_state = CONV;
                end else if (sck_fall) begin
                    do_shift   = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnv_rise) begin
                    do_copy    = 1'b1;
                    set_err    = 1'b1;
                    next_state = CONV;
                end else if (sck_fall) begin
                    do_shift = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Conversion timer runs only while staying in CONV; bit counter only while shifting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            conv_cnt <= 10'd0;
            bit_cnt  <= 5'd0;
        end else begin
            if (state == CONV && next_state == CONV) begin
                conv_cnt <= conv_cnt + 10'd1;
            end else begin
                conv_cnt <= 10'd0;
            end
            if (next_state == SHIFT) begin
                if (do_shift) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end else begin
                bit_cnt <= 5'd0;
            end
        end
    end

    // Sample registers: ramp on each conversion copy; a host write to the same channel wins.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (RST) begin
                sample[i] <= 16'd0;
            end else begin
                if (do_copy && MODE) begin
                    sample[i] <= sample[i] + RAMP_STEP;
                end
                if (DIN_WE && DIN_CH == 3'(i)) begin
                    sample[i] <= DIN;
                end
            end
        end
    end

    // Shift registers take the pre-increment samples on a copy and shift left on SCK falls.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (RST) begin
                shreg[i] <= 16'd0;
            end else if (do_copy) begin
                shreg[i] <= sample[i];
            end else if (do_shift) begin
                shreg[i] <= {shreg[i][14:0], 1'b0};
            end
        end
    end

    // Registered outputs: serial data, BUSY, sticky ERR and the SCK echo.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sdo    <= 8'd0;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
            CLKOUT <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                sdo[i] <= (state != IDLE) ? shreg[i][15] : 1'b0;
            end
            BUSY   <= (state == CONV);
            CLKOUT <= sck_s2;
            if (set_err) begin
                ERR <= 1'b1;
            end
        end
    end

    assign SDO1 = sdo[0];
    assign SDO2 = sdo[1];
    assign SDO3 = sdo[2];
    assign SDO4 = sdo[3];
    assign SDO5 = sdo[4];
    assign SDO6 = sdo[5];
    assign SDO7 = sdo[6];
    assign SDO8 = sdo[7];

endmodule

// File: tb/tb_adc_emulator.sv
// tb_adc_emulator: self-checking bench for adc_emulator. Acts as the ADC
// controller (CNV pulses, SCK readout) and compares recovered words against a
// channel-level model of the sample registers.
`timescale 1ns/1ps
module tb_adc_emulator;

    localparam int          CONV_CYCLES = 10;
    localparam logic [15:0] RAMP_STEP   = 16'd1;

    typedef struct {
        logic        mode;
        logic [2:0]  ch;
        logic [15:0] data;
        logic [15:0] exp_first;
        logic [15:0] exp_second;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, cnv, sck, mode, din_we;
    logic [15:0] din;
    logic [2:0]  din_ch;
    logic        sdo1, sdo2, sdo3, sdo4, sdo5, sdo6, sdo7, sdo8;
    logic        clkout, busy, err;
    logic [7:0]  sdo_bus;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_sample [8];

    assign sdo_bus = {sdo8, sdo7, sdo6, sdo5, sdo4, sdo3, sdo2, sdo1};

    adc_emulator #(.CONV_CYCLES(CONV_CYCLES), .RAMP_STEP(RAMP_STEP)) dut (
        .CLK(clk), .RST(rst), .CNV(cnv), .SCK(sck), .MODE(mode),
        .DIN(din), .DIN_CH(din_ch), .DIN_WE(din_we),
        .SDO1(sdo1), .SDO2(sdo2), .SDO3(sdo3), .SDO4(sdo4),
        .SDO5(sdo5), .SDO6(sdo6), .SDO7(sdo7), .SDO8(sdo8),
        .CLKOUT(clkout), .BUSY(busy), .ERR(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeSample(input logic [2:0] ch, input logic [15:0] data);
        din    = data;
        din_ch = ch;
        din_we = 1'b1;
        tick();
        din_we = 1'b0;
        model_sample[ch] = data;
    endtask

    task automatic applyStimulus(input vec_t v);
        mode = v.mode;
        writeSample(v.ch, v.data);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) tick();
        checkOutput("reset sdo", {8'd0, sdo_bus}, 16'd0);
        checkBit("reset busy", busy, 1'b0);
        checkBit("reset err", err, 1'b0);
        checkBit("reset clkout", clkout, 1'b0);
        rst = 1'b0;
        tick();
        for (int c = 0; c < 8; c++) model_sample[c] = 16'd0;
    endtask

    // CNV is raised in the current cycle (0); an optional host write is placed
    // on the cycle-3 edge, which is when the synchronized rise triggers the copy.
    task automatic startConv(input bit with_write, input logic [2:0] ch, input logic [15:0] data);
        cnv = 1'b1;
        tick();
        tick();
        if (with_write) begin
            din    = data;
            din_ch = ch;
            din_we = 1'b1;
        end
        tick();
        din_we = 1'b0;
        cnv    = 1'b0;
    endtask

    task automatic waitDone();
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (busy) seen = 1'b1;
            else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        checkBit("conversion done", done, 1'b1);
    endtask

    task automatic pulseSck();
        sck = 1'b1;
        repeat (4) tick();
        sck = 1'b0;
        repeat (6) tick();
    endtask

    task automatic readBits(input int n, output logic [7:0][15:0] w);
        w = '0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 8; c++) w[c][15-k] = sdo_bus[c];
            pulseSck();
        end
    endtask

    task automatic compareWords(input string tag, input logic [7:0][15:0] w, input logic [7:0][15:0] exp);
        for (int c = 0; c < 8; c++) checkOutput($sformatf("%s ch%0d", tag, c + 1), w[c], exp[c]);
    endtask

    task automatic runConversion(input string tag, input bit coll, input logic [2:0] cch,
                                 input logic [15:0] cdata, output logic [7:0][15:0] w);
        logic [7:0][15:0] exp;
        for (int c = 0; c < 8; c++) exp[c] = model_sample[c];
        if (mode) for (int c = 0; c < 8; c++) model_sample[c] = model_sample[c] + RAMP_STEP;
        if (coll) model_sample[cch] = cdata;
        startConv(coll, cch, cdata);
        waitDone();
        readBits(16, w);
        compareWords(tag, w, exp);
        tick();
        checkOutput({tag, " idle sdo"}, {8'd0, sdo_bus}, 16'd0);
        checkBit({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        vec_t             vectors [5];
        logic [7:0][15:0] w;
        logic [7:0][15:0] exp;
        logic [15:0]      ramp_exp [3];
        int               first_busy;
        int               busy_cnt;

        vectors[0] = '{1'b0, 3'd3, 16'h1234, 16'h1234, 16'h1234};
        vectors[1] = '{1'b0, 3'd6, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vectors[2] = '{1'b1, 3'd1, 16'hFFFF, 16'hFFFF, 16'h0000};
        vectors[3] = '{1'b1, 3'd4, 16'h7FFE, 16'h7FFE, 16'h7FFF};
        vectors[4] = '{1'b0, 3'd0, 16'h0001, 16'h0001, 16'h0001};
        ramp_exp[0] = 16'hFFFF;
        ramp_exp[1] = 16'h0000;
        ramp_exp[2] = 16'h0001;

        rst = 1'b1; cnv = 1'b0; sck = 1'b0; mode = 1'b0;
        din = 16'd0; din_ch = 3'd0; din_we = 1'b0;
        doReset();

        // Static readout of two written channels, others zero.
        writeSample(3'd0, 16'hA5C3);
        writeSample(3'd7, 16'h8001);
        runConversion("static", 1'b0, 3'd0, 16'd0, w);
        checkOutput("static ch1 const", w[0], 16'hA5C3);
        checkOutput("static ch8 const", w[7], 16'h8001);
        checkOutput("static ch2 const", w[1], 16'h0000);
        checkBit("static err", err, 1'b0);

        // BUSY profile relative to the cycle in which CNV rises.
        for (int c = 0; c < 8; c++) exp[c] = model_sample[c];
        cnv = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checkBit($sformatf("busy cycle %0d", k), busy, (k >= 4 && k < 4 + CONV_CYCLES));
            if (k == 3) cnv = 1'b0;
        end
        readBits(16, w);
        compareWords("timing", w, exp);

        // CLKOUT follows SCK three cycles late; SCK edges in IDLE are harmless.
        sck = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkBit($sformatf("clkout rise cycle %0d", k), clkout, k >= 3);
        end
        sck = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkBit($sformatf("clkout fall cycle %0d", k), clkout, k < 3);
        end
        checkBit("idle sck err", err, 1'b0);

        // Table of single-channel writes, each followed by two conversions.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vectors[i]);
            runConversion($sformatf("vec%0d a", i), 1'b0, 3'd0, 16'd0, w);
            checkOutput($sformatf("vec%0d first", i), w[vectors[i].ch], vectors[i].exp_first);
            runConversion($sformatf("vec%0d b", i), 1'b0, 3'd0, 16'd0, w);
            checkOutput($sformatf("vec%0d second", i), w[vectors[i].ch], vectors[i].exp_second);
        end

        // Ramp wraps modulo 2^16 across three conversions.
        mode = 1'b1;
        writeSample(3'd1, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            runConversion($sformatf("ramp%0d", i), 1'b0, 3'd0, 16'd0, w);
            checkOutput($sformatf("ramp ch2 word %0d", i), w[1], ramp_exp[i]);
        end

        // Host write landing on the copy edge: old value out now, written value next.
        writeSample(3'd2, 16'h0BAD);
        runConversion("collide", 1'b1, 3'd2, 16'h1234, w);
        checkOutput("collide ch3 old", w[2], 16'h0BAD);
        runConversion("after collide", 1'b0, 3'd0, 16'd0, w);
        checkOutput("collide ch3 new", w[2], 16'h1234);

        // Randomized writes and modes against the channel model.
        for (int it = 0; it < 6; it++) begin
            int n;
            mode = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) writeSample(3'($urandom_range(0, 7)), 16'($urandom));
            runConversion($sformatf("rand%0d", it), 1'b0, 3'd0, 16'd0, w);
        end
        checkBit("err after clean traffic", err, 1'b0);

        // SCK fall during CONV is ignored but flagged.
        mode = 1'b0;
        for (int c = 0; c < 8; c++) exp[c] = model_sample[c];
        cnv = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) checkBit("err before sck in conv", err, 1'b0);
            if (k == 1) sck = 1'b1;
            if (k == 3) cnv = 1'b0;
            if (k == 5) sck = 1'b0;
        end
        checkBit("err sck in conv", err, 1'b1);
        readBits(16, w);
        compareWords("sck in conv", w, exp);

        // CNV rise during CONV is ignored, BUSY length unchanged, ERR set.
        doReset();
        writeSample(3'd4, 16'hC0DE);
        writeSample(3'd5, 16'h5A5A);
        for (int c = 0; c < 8; c++) exp[c] = model_sample[c];
        first_busy = -1;
        busy_cnt   = 0;
        cnv = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = k;
            end
            if (k == 2) cnv = 1'b0;
            if (k == 6) cnv = 1'b1;
            if (k == 8) cnv = 1'b0;
        end
        checkOutput("busy length", 16'(busy_cnt), 16'(CONV_CYCLES));
        checkOutput("busy first cycle", 16'(first_busy), 16'd4);
        checkBit("err cnv in conv", err, 1'b1);
        readBits(16, w);
        compareWords("cnv in conv", w, exp);

        // CNV rise after 5 SCK falls aborts the readout and restarts a conversion.
        doReset();
        writeSample(3'd0, 16'h1111);
        writeSample(3'd3, 16'h3333);
        writeSample(3'd7, 16'hFEDC);
        for (int c = 0; c < 8; c++) exp[c] = model_sample[c];
        startConv(1'b0, 3'd0, 16'd0);
        waitDone();
        readBits(5, w);
        checkOutput("abort partial ch8", {11'd0, w[7][15:11]}, {11'd0, exp[7][15:11]});
        checkBit("err before abort", err, 1'b0);
        startConv(1'b0, 3'd0, 16'd0);
        waitDone();
        checkBit("err after abort", err, 1'b1);
        readBits(16, w);
        compareWords("abort", w, exp);

        // Reset in the middle of a readout clears everything next cycle.
        startConv(1'b0, 3'd0, 16'd0);
        waitDone();
        readBits(8, w);
        rst = 1'b1;
        tick();
        checkOutput("midshift rst sdo", {8'd0, sdo_bus}, 16'd0);
        checkBit("midshift rst busy", busy, 1'b0);
        checkBit("midshift rst err", err, 1'b0);
        rst = 1'b0;
        tick();
        for (int c = 0; c < 8; c++) model_sample[c] = 16'd0;
        writeSample(3'd2, 16'h2468);
        writeSample(3'd6, 16'h9BDF);
        runConversion("post reset", 1'b0, 3'd0, 16'd0, w);
        checkBit("post reset err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
